// File: rtl/pn_pkg.sv
// Shared types for the PN spike scheduler: controller states, config field codes
// and the saturating helper used by the optional event counters.
package pn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } pn_state_e;

    localparam logic F_PARAM    = 1'b0;
    localparam logic F_INTERVAL = 1'b1;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pn_rr_arbiter.sv
// Round-robin arbiter over the pending-spike vector; the pointer holds the index
// searched first and moves just past the winner on every issued grant.
module pn_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             grant_en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;

    always_comb begin
        int j;
        j         = 0;
        found     = 1'b0;
        gnt_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!found && req_i[IDX_W'(j)]) begin
                found     = 1'b1;
                gnt_idx_o = IDX_W'(j);
            end
        end
        gnt_o = '0;
        ptr_d = ptr_q;
        if (found && grant_en_i) begin
            gnt_o[gnt_idx_o] = 1'b1;
            ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/pn_spike_scheduler.sv
// Soma-bank controller: config load sequencing, enable/kill, spike capture and a
// timestamped FWFT event FIFO. Define PN_SPIKE_CNT_EN for per-soma event counters.
module pn_spike_scheduler
    import pn_pkg::*;
#(
    parameter int N_SOMA     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      cfg_we,
    input  logic [$clog2(N_SOMA):0]   cfg_addr,
    input  logic [31:0]               cfg_wdata,
    output logic [31:0]               soma_wdata,
    output logic [N_SOMA-1:0]         soma_load,
    output logic [N_SOMA-1:0]         soma_en,
    output logic [N_SOMA-1:0]         soma_kill,
    input  logic [N_SOMA-1:0]         soma_spike,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_SOMA)-1:0] evt_soma,
    output logic [TS_W-1:0]           evt_time,
    output logic                      busy,
    output logic                      overflow
`ifdef PN_SPIKE_CNT_EN
    ,
    input  logic [$clog2(N_SOMA)-1:0] cnt_sel,
    output logic [15:0]               cnt_out
`endif
);

    localparam int IDX_W = $clog2(N_SOMA);
    localparam int AW    = IDX_W + 1;
    localparam int LC_W  = IDX_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TS_W-1:0]  ts;
    } evt_rec_t;

    pn_state_e        state_q;
    logic [LC_W-1:0]  ld_cnt_q;
    logic [TS_W-1:0]  ts_q;
    logic [31:0]      wdata_q;
    logic [N_SOMA-1:0] load_q, en_q, kill_q;
    logic [31:0]      params_q   [N_SOMA];
    logic [15:0]      interval_q [N_SOMA];
    logic [N_SOMA-1:0] pend_q, pend_d, cap_ok;
    logic [TS_W-1:0]  tsl_q [N_SOMA];
    logic             ovf_q, drop;
    logic [N_SOMA-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    evt_rec_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fcnt_q;
    logic             full, push, pop, start_acc;
    logic [IDX_W-1:0] cfg_idx;
    logic [LC_W-1:0]  nxt_cnt;
    logic [IDX_W-1:0] nxt_idx;
    logic [31:0]      nxt_wdata;
    logic [N_SOMA-1:0] nxt_load;
    evt_rec_t         head;

    assign start_acc = (state_q == ST_IDLE) && start && !stop;
    assign cfg_idx   = cfg_addr[AW-1:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SOMA; i++) begin
                params_q[i]   <= '0;
                interval_q[i] <= '0;
            end
        end else if (cfg_we && state_q == ST_IDLE && int'(cfg_idx) < N_SOMA) begin
            if (cfg_addr[0] == F_PARAM) params_q[cfg_idx]   <= cfg_wdata;
            else                        interval_q[cfg_idx] <= cfg_wdata[15:0];
        end
    end

    // Word presented on the shared bus in the next LOAD cycle: even = params, odd = interval
    always_comb begin
        nxt_cnt   = (state_q == ST_IDLE) ? '0 : ld_cnt_q + LC_W'(1);
        nxt_idx   = nxt_cnt[LC_W-1:1];
        nxt_wdata = (nxt_cnt[0] == F_INTERVAL) ? {16'h0, interval_q[nxt_idx]} : params_q[nxt_idx];
        nxt_load  = N_SOMA'(1) << nxt_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ld_cnt_q <= '0;
            ts_q     <= '0;
            wdata_q  <= '0;
            load_q   <= '0;
            en_q     <= '0;
            kill_q   <= '0;
        end else begin
            kill_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        state_q  <= ST_LOAD;
                        ld_cnt_q <= '0;
                        ts_q     <= '0;
                        wdata_q  <= nxt_wdata;
                        load_q   <= nxt_load;
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        kill_q  <= '1;
                        load_q  <= '0;
                        wdata_q <= '0;
                    end else if (ld_cnt_q == LC_W'(2 * N_SOMA - 1)) begin
                        state_q <= ST_RUN;
                        load_q  <= '0;
                        wdata_q <= '0;
                        en_q    <= '1;
                    end else begin
                        ld_cnt_q <= nxt_cnt;
                        wdata_q  <= nxt_wdata;
                        load_q   <= nxt_load;
                    end
                end
                ST_RUN: begin
                    ts_q <= ts_q + TS_W'(1);
                    if (stop) begin
                        state_q <= ST_DRAIN;
                        en_q    <= '0;
                        kill_q  <= '1;
                    end
                end
                ST_DRAIN: begin
                    if (pend_q == '0 && fcnt_q == '0) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A spike on a still-pending soma is lost unless that soma is granted this cycle
    always_comb begin
        pend_d = pend_q;
        cap_ok = '0;
        drop   = 1'b0;
        for (int i = 0; i < N_SOMA; i++) begin
            if (gnt[i]) pend_d[i] = 1'b0;
            if (state_q == ST_RUN && soma_spike[i]) begin
                if (pend_q[i] && !gnt[i]) begin
                    drop = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    cap_ok[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else if (start_acc) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SOMA; i++)
            if (cap_ok[i]) tsl_q[i] <= ts_q;
    end

    pn_rr_arbiter #(
        .N     (N_SOMA),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (pend_q),
        .grant_en_i (!full),
        .gnt_o      (gnt),
        .gnt_idx_o  (gnt_idx)
    );

    // Full is judged on the registered count, so a pop never frees a slot for the same-cycle push
    assign full = (fcnt_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign push = |gnt;
    assign pop  = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + (PTR_W + 1)'(1);
                2'b01:   fcnt_q <= fcnt_q - (PTR_W + 1)'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= '{idx: gnt_idx, ts: tsl_q[gnt_idx]};
    end

`ifdef PN_SPIKE_CNT_EN
    logic [CNT_W-1:0] evcnt_q [N_SOMA];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SOMA; i++) evcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SOMA; i++) begin
                if (start_acc)   evcnt_q[i] <= '0;
                else if (gnt[i]) evcnt_q[i] <= sat_inc(evcnt_q[i]);
            end
        end
    end

    assign cnt_out = evcnt_q[cnt_sel];
`endif

    assign head       = mem[rd_ptr_q];
    assign evt_valid  = (fcnt_q != '0);
    assign evt_soma   = evt_valid ? head.idx : '0;
    assign evt_time   = evt_valid ? head.ts  : '0;
    assign soma_wdata = wdata_q;
    assign soma_load  = load_q;
    assign soma_en    = en_q;
    assign soma_kill  = kill_q;
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = ovf_q;

endmodule
